// File: rtl/stage_mem_if.sv
// MEM-stage bus: execute-side request fields in, MEM/WB register fields out.
// The slave modport is the stage itself; the master is whoever drives the request.
interface stage_mem_if;
    logic        stall;
    logic        flush;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [1:0]  size;
    logic        loadUnsigned;
    logic [31:0] outAlu;
    logic [31:0] writeData;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic [4:0]  writeReg_o;
    logic [31:0] readDataMem;
    logic [31:0] outAlu_o;
    logic        misalign;

    modport slave (
        input  stall, flush, MemRead, MemWrite, MemtoReg, RegWrite, writeReg,
               size, loadUnsigned, outAlu, writeData,
        output MemtoReg_o, RegWrite_o, writeReg_o, readDataMem, outAlu_o, misalign
    );

    modport master (
        output stall, flush, MemRead, MemWrite, MemtoReg, RegWrite, writeReg,
               size, loadUnsigned, outAlu, writeData,
        input  MemtoReg_o, RegWrite_o, writeReg_o, readDataMem, outAlu_o, misalign
    );
endinterface

// File: rtl/stage_mem.sv
// Pipeline MEM stage: little-endian byte/half/word data memory with load
// extension, misalignment detection and the MEM/WB pipeline register.
module stage_mem #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    stage_mem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic              mis;
    logic              store_en;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_data;

    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  writereg_q, writereg_d;
    logic [31:0] readdata_q, readdata_d;
    logic [31:0] outalu_q,   outalu_d;
    logic        misalign_q, misalign_d;

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] ln, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {ln, 3'b000});
        h = 16'(w >> {ln[1], 4'b0000});
        case (sz)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    assign idx     = bus.outAlu[ADDR_W+1:2];
    assign lane    = bus.outAlu[1:0];
    assign rd_word = mem[idx];

    assign mis = (bus.MemRead || bus.MemWrite) &&
                 (((bus.size == 2'b01) && lane[0]) || (bus.size[1] && (lane != 2'b00)));

    // Reset is sampled here too so an edge that lands while reset is high never writes.
    assign store_en = bus.MemWrite && !bus.stall && !bus.flush && !mis && !reset;

    always_comb begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = bus.writeData;
        case (bus.size)
            2'b00: begin
                wr_mask = 32'h0000_00FF << {lane, 3'b000};
                wr_data = {4{bus.writeData[7:0]}};
            end
            2'b01: begin
                wr_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                wr_data = {2{bus.writeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_en)
            mem[idx] <= (mem[idx] & ~wr_mask) | (wr_data & wr_mask);
    end

    always_comb begin
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        writereg_d = writereg_q;
        readdata_d = readdata_q;
        outalu_d   = outalu_q;
        misalign_d = misalign_q;
        if (bus.flush) begin
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            writereg_d = 5'd0;
            readdata_d = 32'd0;
            outalu_d   = 32'd0;
            misalign_d = 1'b0;
        end else if (!bus.stall) begin
            memtoreg_d = bus.MemtoReg;
            regwrite_d = bus.RegWrite && !mis;
            writereg_d = bus.writeReg;
            readdata_d = bus.MemRead ? extend_load(rd_word, bus.size, lane, bus.loadUnsigned) : 32'd0;
            outalu_d   = bus.outAlu;
            misalign_d = mis;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            writereg_q <= 5'd0;
            readdata_q <= 32'd0;
            outalu_q   <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            readdata_q <= readdata_d;
            outalu_q   <= outalu_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.MemtoReg_o  = memtoreg_q;
    assign bus.RegWrite_o  = regwrite_q;
    assign bus.writeReg_o  = writereg_q;
    assign bus.readDataMem = readdata_q;
    assign bus.outAlu_o    = outalu_q;
    assign bus.misalign    = misalign_q;
endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter: ADDR_W, 8, log2 of data-memory depth in 32-bit words (256 words).
REQ-002 Port: clk  input  1  rising-edge clock for the memory array and the MEM/WB register.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: stall  input  1  hold the MEM/WB register and block stores.
REQ-005 Port: flush  input  1  load a bubble into the MEM/WB register.
REQ-006 Port: MemRead  input  1  load request.
REQ-007 Port: MemWrite  input  1  store request.
REQ-008 Port: MemtoReg  input  1  WB select, passed through.
REQ-009 Port: RegWrite  input  1  register-file write enable, passed through.
REQ-010 Port: writeReg  input  5  destination register, passed through.
REQ-011 Port: size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-012 Port: loadUnsigned  input  1  zero-extend, rather than sign-extend, byte and halfword loads.
REQ-013 Port: outAlu  input  32  effective address and ALU result.
REQ-014 Port: writeData  input  32  store data.
REQ-015 Port: MemtoReg_o  output  1  registered MemtoReg.
REQ-016 Port: RegWrite_o  output  1  registered, qualified RegWrite.
REQ-017 Port: writeReg_o  output  5  registered writeReg.
REQ-018 Port: readDataMem  output  32  registered, extended load data.
REQ-019 Port: outAlu_o  output  32  registered outAlu.
REQ-020 Port: misalign  output  1  registered one-cycle flag for a misaligned access.

Function
REQ-021 Memory: 2^ADDR_W x 32 array, indexed by outAlu[ADDR_W+1:2].
- Higher address bits are ignored, so addresses wrap.
- The array is not reset.
REQ-022 Reads: combinational from the array; the extended result is captured into readDataMem at the next rising edge (one-cycle latency).
REQ-023 Byte order: little-endian; byte lane k = bits 8k+7:8k, with k = outAlu[1:0].
REQ-024 Byte load: selects lane outAlu[1:0]; halfword load: selects lane pair outAlu[1]; each is sign- or zero-extended per loadUnsigned.
REQ-025 Byte store: writes writeData[7:0] to the selected lane only.
- Halfword store writes writeData[15:0] to the selected pair only.
- Word store writes all 32 bits.
REQ-026 Stores: take effect at the rising edge when MemWrite=1, stall=0, flush=0 and the access is aligned.
REQ-027 Misalignment: halfword with outAlu[0]=1, or word with outAlu[1:0]!=00, while MemRead or MemWrite is set.
- The store is suppressed.
- RegWrite_o=0 and misalign=1 for that captured cycle.
REQ-028 Same-cycle store and load to one word: the load returns the pre-store contents; the new value is visible from the next cycle.
REQ-029 When MemRead=0, readDataMem captures 0.
REQ-030 Stall (stall=1, flush=0): all MEM/WB outputs hold their values, misalign included; no store occurs.
REQ-031 Flush: MemtoReg_o, RegWrite_o and misalign capture 0; writeReg_o, outAlu_o and readDataMem capture 0; no store occurs.
REQ-032 Flush has priority over stall when both are asserted.
REQ-033 MemRead and MemWrite both asserted: treated as a store, and readDataMem returns the pre-store data.
REQ-034 Normal advance: every MEM/WB output captures its next value on each rising edge without stall or flush.

Reset
REQ-035 While reset=1, asynchronously and independent of clk, all outputs are 0.
REQ-036 Stores are inhibited while reset=1, and memory contents are retained.
REQ-037 Reset asserted mid-stall or mid-store: reset wins, the pending store does not occur, and the outputs clear immediately.
REQ-038 On the first rising edge after reset deasserts, normal capture resumes.

Verification
REQ-039 Word store then load: store 0xDEADBEEF to address 0x10, then load word from 0x10 -> readDataMem=0xDEADBEEF one cycle after the load is presented, with outAlu_o=0x10.
REQ-040 Byte and halfword extension from word 0x80F0_7F81 at address 0x20:
- lb 0x20 -> 0xFFFFFF81
- lbu 0x20 -> 0x00000081
- lh 0x22 -> 0xFFFF80F0
- lhu 0x22 -> 0x000080F0
REQ-041 Partial store: store byte 0xAA to 0x21 over 0x11223344 -> the next word load returns 0x1122AA44.
REQ-042 Misalignment: word load at 0x13 with RegWrite=1 -> RegWrite_o=0 and misalign=1 for one cycle; a word store at 0x13 leaves memory unchanged.
REQ-043 Stall then flush: hold stall=1 for 2 cycles with MemWrite=1 -> outputs frozen and no write; then stall=1 with flush=1 -> RegWrite_o=0 and MemtoReg_o=0.
REQ-044 Address wrap and reset: store 0x5 to 0x400 -> a word load from 0x0 returns 0x5; assert reset mid-store -> all outputs 0 and the target word unchanged.
